// File: rtl/i2c_reg_ctrl.sv
// Register-access controller between an I2C slave byte interface and a single-port
// configuration register bank, with arbitration against an internal requester.
module i2c_reg_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int NREGS   = 16,
  parameter int AUTOINC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_in,
  input  logic              rnw_in,
  input  logic              frame_end_in,
  input  logic              rx_valid_in,
  input  logic [7:0]        rx_data_in,
  input  logic              tx_req_in,
  output logic [7:0]        tx_data_out,
  output logic              tx_valid_out,
  output logic              underrun_out,
  input  logic              int_req_in,
  input  logic              int_we_in,
  input  logic [ADDR_W-1:0] int_addr_in,
  input  logic [7:0]        int_wdata_in,
  output logic              int_gnt_out,
  output logic              int_rvalid_out,
  output logic [7:0]        int_rdata_out,
  output logic              bank_en_out,
  output logic              bank_we_out,
  output logic [ADDR_W-1:0] bank_addr_out,
  output logic [7:0]        bank_wdata_out,
  input  logic [7:0]        bank_rdata_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_PTR, S_WR, S_RD_FETCH, S_RD_WAIT, S_RD_HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_pend;
  logic              rd_issue;
  logic              i2c_access;

  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    if (AUTOINC == 0) return p;
    if (p == ADDR_W'(NREGS - 1)) return '0;
    return p + ADDR_W'(1);
  endfunction

  // Pointer byte keeps its low ADDR_W bits, then folds into the populated range.
  function automatic logic [ADDR_W-1:0] ptr_load(input logic [7:0] b);
    return ADDR_W'((32'(b) % (32'd1 << ADDR_W)) % 32'(NREGS));
  endfunction

  // A pending write has priority over a fetch, so the fetch simply stalls a cycle.
  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    rd_issue       = (state == S_RD_FETCH) && !wr_pend && !rst;
    i2c_access     = (wr_pend && !rst) || rd_issue;
    int_gnt_out    = int_req_in && !i2c_access && !rst;
    bank_en_out    = 1'b0;
    bank_we_out    = 1'b0;
    bank_addr_out  = '0;
    bank_wdata_out = '0;
    if (wr_pend && !rst) begin
      bank_en_out    = 1'b1;
      bank_we_out    = 1'b1;
      bank_addr_out  = wr_addr;
      bank_wdata_out = wr_data;
    end else if (rd_issue) begin
      bank_en_out    = 1'b1;
      bank_addr_out  = ptr_r;
    end else if (int_gnt_out) begin
      bank_en_out    = 1'b1;
      bank_we_out    = int_we_in;
      bank_addr_out  = int_addr_in;
      bank_wdata_out = int_wdata_in;
    end
  end

  assign int_rdata_out = int_rvalid_out ? bank_rdata_in : 8'h00;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr_r          <= '0;
      wr_addr        <= '0;
      wr_data        <= 8'h00;
      wr_pend        <= 1'b0;
      tx_data_out    <= 8'h00;
      tx_valid_out   <= 1'b0;
      underrun_out   <= 1'b0;
      int_rvalid_out <= 1'b0;
    end else begin
      wr_pend        <= 1'b0;
      int_rvalid_out <= int_gnt_out && !int_we_in;
      case (state)
        S_IDLE: ;
        S_PTR: begin
          if (rx_valid_in) begin
            ptr_r <= ptr_load(rx_data_in);
            state <= S_WR;
          end
        end
        S_WR: begin
          // Capture now, write next cycle; survives a same-cycle frame end.
          if (rx_valid_in) begin
            wr_pend <= 1'b1;
            wr_data <= rx_data_in;
            wr_addr <= ptr_r;
            ptr_r   <= ptr_next(ptr_r);
          end
        end
        S_RD_FETCH: begin
          if (!wr_pend) state <= S_RD_WAIT;
          if (tx_req_in) underrun_out <= 1'b1;
        end
        S_RD_WAIT: begin
          tx_data_out  <= bank_rdata_in;
          tx_valid_out <= 1'b1;
          ptr_r        <= ptr_next(ptr_r);
          state        <= S_RD_HOLD;
          if (tx_req_in) underrun_out <= 1'b1;
        end
        S_RD_HOLD: begin
          if (tx_req_in) begin
            tx_valid_out <= 1'b0;
            state        <= S_RD_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (frame_end_in) begin
        state        <= S_IDLE;
        tx_valid_out <= 1'b0;
      end
      // A start (including a repeated start) overrides everything else this cycle.
      if (frame_start_in) begin
        state        <= rnw_in ? S_RD_FETCH : S_PTR;
        tx_valid_out <= 1'b0;
        underrun_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl with a behavioural single-port register bank.
module tb_i2c_reg_ctrl;
  localparam int ADDR_W = 4;

  logic              clk, rst;
  logic              frame_start_in, rnw_in, frame_end_in, rx_valid_in, tx_req_in;
  logic [7:0]        rx_data_in, tx_data_out;
  logic              tx_valid_out, underrun_out;
  logic              int_req_in, int_we_in, int_gnt_out, int_rvalid_out;
  logic [ADDR_W-1:0] int_addr_in, bank_addr_out;
  logic [7:0]        int_wdata_in, int_rdata_out, bank_wdata_out, bank_rdata_in;
  logic              bank_en_out, bank_we_out;

  logic [7:0] mem [16];
  logic       mem_init;
  int         checks = 0;
  int         errors = 0;

  i2c_reg_ctrl #(.ADDR_W(ADDR_W), .NREGS(16), .AUTOINC(1)) dut (
    .clk(clk), .rst(rst),
    .frame_start_in(frame_start_in), .rnw_in(rnw_in), .frame_end_in(frame_end_in),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in), .tx_req_in(tx_req_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .underrun_out(underrun_out),
    .int_req_in(int_req_in), .int_we_in(int_we_in), .int_addr_in(int_addr_in),
    .int_wdata_in(int_wdata_in), .int_gnt_out(int_gnt_out), .int_rvalid_out(int_rvalid_out),
    .int_rdata_out(int_rdata_out), .bank_en_out(bank_en_out), .bank_we_out(bank_we_out),
    .bank_addr_out(bank_addr_out), .bank_wdata_out(bank_wdata_out), .bank_rdata_in(bank_rdata_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank preloads to 8'hC0 + index, so untouched register i reads back C<i>.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'hC0 + i);
    end else if (bank_en_out) begin
      if (bank_we_out) mem[bank_addr_out] <= bank_wdata_out;
      else             bank_rdata_in      <= mem[bank_addr_out];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic rnw);
    @(negedge clk); frame_start_in = 1'b1; rnw_in = rnw;
    @(negedge clk); frame_start_in = 1'b0; rnw_in = 1'b0;
  endtask

  task automatic pulse_end();
    @(negedge clk); frame_end_in = 1'b1;
    @(negedge clk); frame_end_in = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk); tx_req_in = 1'b1;
    @(negedge clk); tx_req_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid_in = 1'b1; rx_data_in = b;
    @(negedge clk); rx_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1; int_req_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid_out); end
    checks++; if (tx_data_out !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data_out); end
    checks++; if (underrun_out !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", underrun_out); end
    checks++; if (int_gnt_out !== 1'b0) begin errors++; $display("FAIL rst_int_gnt: got %b want 0", int_gnt_out); end
    checks++; if (bank_en_out !== 1'b0) begin errors++; $display("FAIL rst_bank_en: got %b want 0", bank_en_out); end
    checks++; if (int_rvalid_out !== 1'b0) begin errors++; $display("FAIL rst_int_rvalid: got %b want 0", int_rvalid_out); end
    @(negedge clk); rst = 1'b0; mem_init = 1'b0; int_req_in = 1'b0;
  endtask

  task automatic test_write();
    pulse_start(1'b0);
    send_byte(8'h03); #1;
    checks++; if (bank_en_out !== 1'b0) begin errors++; $display("FAIL ptr_no_write: bank_en got %b want 0", bank_en_out); end
    send_byte(8'hA5); #1;
    checks++; if ({bank_en_out, bank_we_out, bank_addr_out, bank_wdata_out} !== {1'b1, 1'b1, 4'd3, 8'hA5}) begin
      errors++; $display("FAIL wr_strobe: got en=%b we=%b a=%h d=%h want en=1 we=1 a=3 d=a5",
                         bank_en_out, bank_we_out, bank_addr_out, bank_wdata_out); end
    send_byte(8'h5A);
    pulse_end();
    checks++; if (mem[3] !== 8'hA5) begin errors++; $display("FAIL wr_bank3: got %h want a5", mem[3]); end
    checks++; if (mem[4] !== 8'h5A) begin errors++; $display("FAIL wr_bank4: got %h want 5a", mem[4]); end
  endtask

  task automatic test_read();
    pulse_start(1'b1);
    checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL rd_lat1: tx_valid got %b want 0", tx_valid_out); end
    @(negedge clk);
    checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL rd_lat2: tx_valid got %b want 0", tx_valid_out); end
    @(negedge clk);
    checks++; if ({tx_valid_out, tx_data_out} !== {1'b1, 8'hC5}) begin
      errors++; $display("FAIL rd_first: got v=%b d=%h want v=1 d=c5", tx_valid_out, tx_data_out); end
    pulse_req();
    checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL rd_req_clear: tx_valid got %b want 0", tx_valid_out); end
    repeat (2) @(negedge clk);
    checks++; if ({tx_valid_out, tx_data_out} !== {1'b1, 8'hC6}) begin
      errors++; $display("FAIL rd_second: got v=%b d=%h want v=1 d=c6", tx_valid_out, tx_data_out); end
    checks++; if (underrun_out !== 1'b0) begin errors++; $display("FAIL rd_no_underrun: got %b want 0", underrun_out); end
    pulse_end();
    checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL rd_end: tx_valid got %b want 0", tx_valid_out); end
  endtask

  task automatic test_wrap();
    pulse_start(1'b0);
    send_byte(8'h0F); send_byte(8'h11); send_byte(8'h22);
    pulse_end();
    checks++; if (mem[15] !== 8'h11) begin errors++; $display("FAIL wrap_bank15: got %h want 11", mem[15]); end
    checks++; if (mem[0] !== 8'h22) begin errors++; $display("FAIL wrap_bank0: got %h want 22", mem[0]); end
    pulse_start(1'b1);
    repeat (2) @(negedge clk);
    checks++; if ({tx_valid_out, tx_data_out} !== {1'b1, 8'hC1}) begin
      errors++; $display("FAIL wrap_ptr1: got v=%b d=%h want v=1 d=c1", tx_valid_out, tx_data_out); end
    pulse_end();
    pulse_start(1'b0);
    send_byte(8'h13); send_byte(8'h77);
    pulse_end();
    checks++; if (mem[3] !== 8'h77) begin errors++; $display("FAIL ptr_high_bits: bank3 got %h want 77", mem[3]); end
  endtask

  task automatic test_collision();
    pulse_start(1'b0);
    send_byte(8'h08);
    @(negedge clk); rx_valid_in = 1'b1; rx_data_in = 8'h99;
    @(negedge clk); rx_valid_in = 1'b0;
    int_req_in = 1'b1; int_we_in = 1'b0; int_addr_in = 4'd3; #1;
    checks++; if ({int_gnt_out, bank_addr_out} !== {1'b0, 4'd8}) begin
      errors++; $display("FAIL col_wr_deny: got gnt=%b a=%h want gnt=0 a=8", int_gnt_out, bank_addr_out); end
    @(negedge clk); #1;
    checks++; if ({int_gnt_out, bank_we_out, bank_addr_out} !== {1'b1, 1'b0, 4'd3}) begin
      errors++; $display("FAIL col_wr_grant: got gnt=%b we=%b a=%h want gnt=1 we=0 a=3", int_gnt_out, bank_we_out, bank_addr_out); end
    @(negedge clk); int_req_in = 1'b0; #1;
    checks++; if ({int_rvalid_out, int_rdata_out} !== {1'b1, 8'h77}) begin
      errors++; $display("FAIL int_read: got v=%b d=%h want v=1 d=77", int_rvalid_out, int_rdata_out); end
    @(negedge clk);
    checks++; if (int_rvalid_out !== 1'b0) begin errors++; $display("FAIL int_rvalid_pulse: got %b want 0", int_rvalid_out); end
    pulse_end();
    checks++; if (mem[8] !== 8'h99) begin errors++; $display("FAIL col_bank8: got %h want 99", mem[8]); end
    pulse_start(1'b1);
    int_req_in = 1'b1; int_we_in = 1'b1; int_addr_in = 4'd2; int_wdata_in = 8'hEE; #1;
    checks++; if (int_gnt_out !== 1'b0) begin errors++; $display("FAIL col_rd_deny: gnt got %b want 0", int_gnt_out); end
    @(negedge clk); #1;
    checks++; if (int_gnt_out !== 1'b1) begin errors++; $display("FAIL col_rd_grant: gnt got %b want 1", int_gnt_out); end
    @(negedge clk); int_req_in = 1'b0; int_we_in = 1'b0;
    checks++; if ({tx_valid_out, tx_data_out} !== {1'b1, 8'hC9}) begin
      errors++; $display("FAIL col_rd_data: got v=%b d=%h want v=1 d=c9", tx_valid_out, tx_data_out); end
    checks++; if (mem[2] !== 8'hEE) begin errors++; $display("FAIL int_write: bank2 got %h want ee", mem[2]); end
    pulse_end();
  endtask

  task automatic test_underrun();
    pulse_start(1'b1);
    @(negedge clk); tx_req_in = 1'b1;
    @(negedge clk); tx_req_in = 1'b0;
    checks++; if (underrun_out !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b want 1", underrun_out); end
    checks++; if ({tx_valid_out, tx_data_out} !== {1'b1, 8'hCA}) begin
      errors++; $display("FAIL underrun_data: got v=%b d=%h want v=1 d=ca", tx_valid_out, tx_data_out); end
    pulse_end();
    checks++; if ({underrun_out, tx_valid_out} !== 2'b10) begin
      errors++; $display("FAIL underrun_sticky: got u=%b v=%b want u=1 v=0", underrun_out, tx_valid_out); end
    pulse_start(1'b0);
    checks++; if (underrun_out !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b want 0", underrun_out); end
    pulse_end();
  endtask

  task automatic test_abort();
    pulse_start(1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL rst_abort: tx_valid got %b want 0", tx_valid_out); end
    pulse_start(1'b1);
    repeat (2) @(negedge clk);
    checks++; if ({tx_valid_out, tx_data_out} !== {1'b1, 8'h22}) begin
      errors++; $display("FAIL rst_ptr0: got v=%b d=%h want v=1 d=22", tx_valid_out, tx_data_out); end
    pulse_req();
    pulse_end();
    repeat (2) @(negedge clk);
    checks++; if (tx_valid_out !== 1'b0) begin errors++; $display("FAIL end_abort: tx_valid got %b want 0", tx_valid_out); end
  endtask

  task automatic test_back_to_back();
    pulse_start(1'b0);
    @(negedge clk); rx_valid_in = 1'b1; rx_data_in = 8'h0C;
    @(negedge clk); rx_data_in = 8'hD1;
    @(negedge clk); rx_data_in = 8'hD2;
    @(negedge clk); rx_data_in = 8'hD3; frame_end_in = 1'b1;
    @(negedge clk); rx_valid_in = 1'b0; frame_end_in = 1'b0;
    @(negedge clk);
    checks++; if ({mem[12], mem[13], mem[14]} !== 24'hD1D2D3) begin
      errors++; $display("FAIL b2b_writes: got %h %h %h want d1 d2 d3", mem[12], mem[13], mem[14]); end
    pulse_start(1'b0);
    send_byte(8'h0F);
    pulse_start(1'b1);
    repeat (2) @(negedge clk);
    checks++; if ({tx_valid_out, tx_data_out} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL repeated_start: got v=%b d=%h want v=1 d=11", tx_valid_out, tx_data_out); end
    pulse_end();
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    frame_start_in = 1'b0; rnw_in = 1'b0; frame_end_in = 1'b0;
    rx_valid_in = 1'b0; rx_data_in = 8'h00; tx_req_in = 1'b0;
    int_req_in = 1'b0; int_we_in = 1'b0; int_addr_in = '0; int_wdata_in = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_collision();
    test_underrun();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
